// File: rtl/mchan_cmd_arbiter.sv
// ============================================================================
// Module  : mchan_cmd_arbiter
// Brief   : Round-robin command arbiter with a registered output slot and
//           per-requester outstanding credits. MCHAN_ARB_PRIO_EN adds prio_i.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mchan_cmd_arbiter #(
  parameter int NB_REQ          = 4,
  parameter int CMD_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 2,
  parameter int LOG_NB_REQ      = $clog2(NB_REQ),
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NB_REQ-1:0]                    req_i,
  output logic [NB_REQ-1:0]                    gnt_o,
  input  logic [NB_REQ-1:0][CMD_WIDTH-1:0]     dat_i,
`ifdef MCHAN_ARB_PRIO_EN
  input  logic [NB_REQ-1:0]                    prio_i,
`endif
  output logic                                 req_o,
  input  logic                                 gnt_i,
  output logic [CMD_WIDTH-1:0]                 dat_o,
  output logic [LOG_NB_REQ-1:0]                id_o,
  input  logic                                 done_i,
  input  logic [LOG_NB_REQ-1:0]                done_id_i,
  output logic [NB_REQ-1:0]                    busy_o
);

  localparam int                     IW    = LOG_NB_REQ + 1;
  localparam logic [CNT_WIDTH-1:0]   C_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [IW-1:0]          C_NB  = IW'(NB_REQ);
  localparam logic [LOG_NB_REQ-1:0]  C_LAST = LOG_NB_REQ'(NB_REQ - 1);

  logic                  r_valid;
  logic [CMD_WIDTH-1:0]  r_dat;
  logic [LOG_NB_REQ-1:0] r_id;
  logic [LOG_NB_REQ-1:0] r_ptr;

  logic                  w_slot_free;
  logic [NB_REQ-1:0]     w_elig;
  logic [NB_REQ-1:0]     w_cand;
  logic                  w_found;
  logic [LOG_NB_REQ-1:0] w_win;
  logic                  w_grant;
  logic [LOG_NB_REQ-1:0] w_ptr_nxt;

  assign w_slot_free = !r_valid || gnt_i;

`ifdef MCHAN_ARB_PRIO_EN
  logic [NB_REQ-1:0] w_hi;
  assign w_hi   = w_elig & prio_i;
  assign w_cand = (|w_hi) ? w_hi : w_elig;
`else
  assign w_cand = w_elig;
`endif

  // Circular scan starting at the pointer; first candidate wins.
  always_comb begin : p_scan
    logic [IW-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IW'(k);
      if (w_idx >= C_NB) begin
        w_idx = w_idx - C_NB;
      end
      if (!w_found && w_cand[w_idx[LOG_NB_REQ-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[LOG_NB_REQ-1:0];
      end
    end
  end

  // Gated by rst_ni so the grant is also held low while reset is asserted.
  assign w_grant   = rst_ni && w_slot_free && w_found;
  assign w_ptr_nxt = (w_win == C_LAST) ? '0 : w_win + 1'b1;

  always_comb begin
    gnt_o = '0;
    if (w_grant) begin
      gnt_o[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_dat   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_slot_free) begin
        r_valid <= w_grant;
      end
      if (w_grant) begin
        r_dat <= dat_i[w_win];
        r_id  <= w_win;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign req_o = r_valid;
  assign dat_o = r_dat;
  assign id_o  = r_id;

  // Credit is taken at grant time, so a command parked in the slot counts.
  for (genvar i = 0; i < NB_REQ; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_inc;
    logic                 w_dec;

    assign w_inc = gnt_o[i];
    assign w_dec = done_i && (done_id_i == LOG_NB_REQ'(i)) && (r_cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_elig[i] = req_i[i] && (r_cnt < C_MAX);
    assign busy_o[i] = (r_cnt != '0);
  end

endmodule

`default_nettype wire

// File: doc/mchan_cmd_arbiter.md
Name: mchan_cmd_arbiter

Overview:
- Shares the single transfer-queue push port between NB_REQ command sources (core command interfaces, cluster controller).
- Round-robin arbitration, one registered output slot, per-requester outstanding-transfer credit limit.
- Sits directly upstream of the transfer queue: its req_o/gnt_i/dat_o drive the queue's push handshake; id_o travels alongside for completion tracking.

Parameters:
- NB_REQ, 4, number of requesters (>=2)
- CMD_WIDTH, 10, command word width (same as the transfer-queue width)
- MAX_OUTSTANDING, 2, maximum granted-but-not-completed commands per requester (>=1)
- LOG_NB_REQ, $clog2(NB_REQ), requester ID width (derived)
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding-counter width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NB_REQ  per-requester command valid
- gnt_o  out  NB_REQ  per-requester grant; command accepted this cycle
- dat_i  in  NB_REQ x CMD_WIDTH  per-requester command word
- req_o  out  1  output command valid (toward the queue push port)
- gnt_i  in  1  queue accepts the output command
- dat_o  out  CMD_WIDTH  output command word
- id_o  out  LOG_NB_REQ  source requester of dat_o
- done_i  in  1  one transfer completed (one-cycle pulse)
- done_id_i  in  LOG_NB_REQ  requester owning the completed transfer
- busy_o  out  NB_REQ  requester has outstanding count != 0

Behaviour:
- Reset: req_o=0, dat_o=0, id_o=0, gnt_o=0, busy_o=0; all counters 0; RR pointer 0.
- Output slot: one register (valid, dat, id).
  - slot_free = !req_o || gnt_i.
  - Pop = req_o && gnt_i.
  - While req_o=1 and gnt_i=0, dat_o and id_o are held stable.
- Eligibility: requester i is eligible when req_i[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Grant:
  - Only when slot_free=1 and at least one requester is eligible.
  - Winner is the first eligible index scanning ptr, ptr+1, ..., NB_REQ-1, 0, ..., ptr-1.
  - gnt_o is one-hot or zero, combinational in the same cycle.
  - Grant and pop in the same cycle give back-to-back throughput of 1 command/cycle.
- Latency: dat_i accepted at edge k appears on dat_o/req_o from cycle k+1.
- RR pointer: on a grant to winner w, ptr <= w+1, wrapping NB_REQ-1 -> 0. Unchanged when there is no grant.
- Counters, per requester i:
  - inc = grant to i; dec = done_i && done_id_i==i.
  - inc only: +1. dec only: -1. Both: unchanged.
  - dec with cnt=0 is ignored (saturate at 0). An inc at MAX is impossible by eligibility.
  - Counters count from grant, not from pop; a command waiting in the slot already consumes credit.
- busy_o[i] = (cnt[i] != 0), registered view of the counters.
- Requester protocol: a requester may drop req_i without a grant; the arbiter does not require sticky requests.
- done_id_i >= NB_REQ: ignored.
- Asynchronous reset mid-operation drops any slot content and all credits immediately.

Optional Feature:
- Macro: MCHAN_ARB_PRIO_EN.
- Defined:
  - Adds input port prio_i [NB_REQ].
  - Eligible requesters with prio_i=1 are arbitrated first, round-robin among themselves with the same pointer.
  - Low-priority requesters are granted only when no eligible high-priority requester exists.
  - Credit limits still apply to high-priority requesters.
- Undefined: no prio_i port; pure round-robin as above.

Test Plan:
- Reset, then idle: req_o=0, gnt_o=0, busy_o=0. Assert rst_ni=0 while the slot is valid: req_o drops to 0 asynchronously.
- Round-robin fairness: req_i=4'b1111 continuously, gnt_i=1, done_i pulsed for each popped id.
  - Grants cycle through 0,1,2,3,0...
  - id_o lags gnt_o by one cycle; one command per cycle.
- Backpressure: gnt_i=0 for 5 cycles with req_o=1.
  - dat_o and id_o stay constant; gnt_o=0 throughout.
  - First gnt_i=1 cycle pops and grants the next requester in the same cycle.
- Credit limit, MAX_OUTSTANDING=2: only req_i[2]=1, no done_i.
  - Exactly 2 grants, then gnt_o[2]=0 indefinitely; busy_o[2]=1.
  - Pulse done_i with done_id_i=2: a third grant follows within 1 cycle.
- Simultaneous events:
  - done_i for id 1 in the same cycle as a grant to 1: cnt[1] unchanged.
  - done_i for an id with cnt=0: no change, no underflow.
- With MCHAN_ARB_PRIO_EN: req_i=4'b1111, prio_i=4'b0100.
  - Requester 2 wins until it is credit-limited.
  - Then 0,1,3 are served round-robin.
